// File: rtl/sha256_round_controller.sv
// rtl/sha256_round_controller.sv - SHA-256 block sequencer: word load, schedule expansion, K ROM, chaining, digest handshake
// Define SHA224_MODE_EN to add the mode224 input (SHA-224 IV and truncated digest).
module sha256_round_controller #(
    parameter int unsigned DONE_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         msg_valid,
    output logic         msg_ready,
    input  logic [31:0]  msg_word,
    input  logic         msg_first,
    input  logic         msg_last,
`ifdef SHA224_MODE_EN
    input  logic         mode224,
`endif
    output logic         core_start,
    output logic [31:0]  core_w,
    output logic [31:0]  core_k,
    output logic [255:0] core_h,
    input  logic         core_done,
    input  logic [255:0] core_h_out,
    output logic [255:0] digest,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic         busy,
    output logic [5:0]   round_idx,
    output logic         err
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD      = 3'd1;
    localparam logic [2:0] ROUND     = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] UPDATE    = 3'd4;
    localparam logic [2:0] OUT       = 3'd5;

    localparam logic [255:0] IV_256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
`ifdef SHA224_MODE_EN
    localparam logic [255:0] IV_224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
`endif

    localparam logic [16:0] TMO_LAST = 17'(DONE_TIMEOUT - 1);

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    logic [2:0]   state;
    logic [2:0]   state_nxt;
    logic         ready_q;
    logic [31:0]  wbuf [16];
    logic [3:0]   widx;
    logic [5:0]   t;
    logic [16:0]  wcnt;
    logic [255:0] h_q;
    logic [255:0] digest_q;
    logic         err_q;
    logic         first_q;
    logic         last_q;
    logic [255:0] iv;
    logic [255:0] digest_next;
    logic         accept;
    logic         timeout;
    logic [3:0]   t_lo;
    logic [3:0]   idx_m2;
    logic [3:0]   idx_m7;
    logic [3:0]   idx_m15;
    logic [31:0]  w_exp;
    logic [31:0]  w_cur;

`ifdef SHA224_MODE_EN
    logic mode_q;
    assign iv          = mode_q ? IV_224 : IV_256;
    assign digest_next = mode_q ? {h_q[255:32], 32'h0} : h_q;
`else
    assign iv          = IV_256;
    assign digest_next = h_q;
`endif

    assign accept  = msg_valid && ready_q;
    assign timeout = (wcnt >= TMO_LAST);

    // Schedule lives in a 16-entry ring: slot t%16 holds W[t-16] until overwritten by W[t].
    assign t_lo    = t[3:0];
    assign idx_m2  = t_lo - 4'd2;
    assign idx_m7  = t_lo - 4'd7;
    assign idx_m15 = t_lo - 4'd15;
    assign w_exp   = ssig1(wbuf[idx_m2]) + wbuf[idx_m7] + ssig0(wbuf[idx_m15]) + wbuf[t_lo];
    assign w_cur   = (t[5:4] == 2'b00) ? wbuf[t_lo] : w_exp;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept) state_nxt = LOAD;
            LOAD:      if (accept && widx == 4'd15) state_nxt = ROUND;
            ROUND:     if (t == 6'd63) state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (core_done)    state_nxt = UPDATE;
                else if (timeout) state_nxt = IDLE;
            end
            UPDATE:    state_nxt = last_q ? OUT : IDLE;
            OUT:       if (digest_ready) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // ready is registered so it stays low through reset and rises one cycle after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ready_q  <= 1'b0;
            widx     <= 4'd0;
            t        <= 6'd0;
            wcnt     <= 17'd0;
            h_q      <= IV_256;
            digest_q <= '0;
            err_q    <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
`ifdef SHA224_MODE_EN
            mode_q   <= 1'b0;
`endif
            for (int i = 0; i < 16; i++) wbuf[i] <= '0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == IDLE) || (state_nxt == LOAD);
            case (state)
                IDLE: begin
                    if (accept) begin
                        wbuf[0] <= msg_word;
                        first_q <= msg_first;
                        last_q  <= msg_last;
                        widx    <= 4'd1;
`ifdef SHA224_MODE_EN
                        if (msg_first) mode_q <= mode224;
`endif
                    end
                end
                LOAD: begin
                    t <= 6'd0;
                    if (accept) begin
                        wbuf[widx] <= msg_word;
                        widx       <= widx + 4'd1;
                        if (widx == 4'd15 && first_q) h_q <= iv;
                    end
                end
                ROUND: begin
                    if (t[5:4] != 2'b00) wbuf[t_lo] <= w_exp;
                    t    <= t + 6'd1;
                    wcnt <= 17'd1;
                end
                WAIT_DONE: begin
                    wcnt <= wcnt + 17'd1;
                    if (core_done)    h_q   <= core_h_out;
                    else if (timeout) err_q <= 1'b1;
                end
                UPDATE: begin
                    if (last_q) digest_q <= digest_next;
                end
                default: ;
            endcase
        end
    end

    assign msg_ready    = ready_q;
    assign core_start   = (state == ROUND);
    assign core_w       = core_start ? w_cur : 32'd0;
    assign core_k       = core_start ? K_ROM[t] : 32'd0;
    assign core_h       = (state == ROUND || state == WAIT_DONE) ? h_q : 256'd0;
    assign round_idx    = core_start ? t : 6'd0;
    assign digest       = digest_q;
    assign digest_valid = (state == OUT);
    assign busy         = (state != IDLE);
    assign err          = err_q;

endmodule

// File: tb/tb_sha256_round_controller.sv
// tb/tb_sha256_round_controller.sv - scoreboard bench for sha256_round_controller with a behavioural round core
module tb_sha256_round_controller;

    localparam logic [255:0] ABC_DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] TWO_DIG = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    typedef struct {
        logic [5:0]  t;
        logic [31:0] w;
    } w_exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         msg_valid;
    logic         msg_ready;
    logic [31:0]  msg_word;
    logic         msg_first;
    logic         msg_last;
    logic         core_start;
    logic [31:0]  core_w;
    logic [31:0]  core_k;
    logic [255:0] core_h;
    logic         core_done;
    logic [255:0] core_h_out;
    logic [255:0] digest;
    logic         digest_valid;
    logic         digest_ready;
    logic         busy;
    logic [5:0]   round_idx;
    logic         err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [255:0] dig_q [$];
    w_exp_t       w_q [$];
    bit           hang = 0;
    bit           pend = 0;
    int           lat  = 0;
    int           rdy_in_round = 0;
    logic [255:0] hin;
    logic [31:0]  wv [8];
    logic [31:0]  abc_blk [16];
    logic [31:0]  tb1 [16];
    logic [31:0]  tb2 [16];

    always #5 clk = ~clk;

    sha256_round_controller #(.DONE_TIMEOUT(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .msg_word     (msg_word),
        .msg_first    (msg_first),
        .msg_last     (msg_last),
        .core_start   (core_start),
        .core_w       (core_w),
        .core_k       (core_k),
        .core_h       (core_h),
        .core_done    (core_done),
        .core_h_out   (core_h_out),
        .digest       (digest),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready),
        .busy         (busy),
        .round_idx    (round_idx),
        .err          (err)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Behavioural compression core: consumes the controller's W/K stream, answers 2 cycles after t=63.
    task automatic core_model();
        logic [31:0] t1;
        logic [31:0] t2;
        forever begin
            @(negedge clk);
            if (core_start) begin
                if (msg_ready) rdy_in_round++;
                if (round_idx == 6'd0) begin
                    hin = core_h;
                    for (int i = 0; i < 8; i++) wv[i] = core_h[255-32*i -: 32];
                end
                if (w_q.size() > 0 && w_q[0].t == round_idx) begin
                    check($sformatf("core_w_t%0d", round_idx), 256'(core_w), 256'(w_q[0].w));
                    void'(w_q.pop_front());
                end
                t1 = wv[7] + (rr(wv[4], 6) ^ rr(wv[4], 11) ^ rr(wv[4], 25))
                     + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6])) + core_k + core_w;
                t2 = (rr(wv[0], 2) ^ rr(wv[0], 13) ^ rr(wv[0], 22))
                     + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
                wv[7] = wv[6]; wv[6] = wv[5]; wv[5] = wv[4]; wv[4] = wv[3] + t1;
                wv[3] = wv[2]; wv[2] = wv[1]; wv[1] = wv[0]; wv[0] = t1 + t2;
                if (round_idx == 6'd63) begin
                    pend = 1;
                    lat  = 0;
                end
            end
            core_done = 1'b0;
            if (pend && !hang) begin
                lat++;
                if (lat == 2) begin
                    for (int i = 0; i < 8; i++) core_h_out[255-32*i -: 32] = hin[255-32*i -: 32] + wv[i];
                    core_done = 1'b1;
                    pend = 0;
                end
            end
        end
    endtask

    task automatic send_block(input logic [31:0] blk [16], input logic first, input logic last, input bit toggle);
        int i = 0;
        int n = 0;
        bit acc = 0;
        while (n < 200) begin
            @(posedge clk); #1;
            if (acc) i++;
            if (i == 16) break;
            msg_valid = toggle ? (n[0] == 1'b0) : 1'b1;
            msg_word  = blk[i];
            msg_first = first;
            msg_last  = last;
            @(negedge clk);
            acc = msg_valid && msg_ready;
            n++;
        end
        msg_valid = 1'b0;
        check("load_count", 256'(i), 256'(16));
    endtask

    task automatic wait_round(input logic [5:0] t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(core_start && round_idx == t) && n < 300);
        check($sformatf("reach_round_%0d", t), 256'(core_start && round_idx == t), 256'(1));
    endtask

    task automatic wait_digest(input int hold);
        int n = 0;
        logic [255:0] d0;
        logic [255:0] exp;
        while (!digest_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("digest_valid", 256'(digest_valid), 256'(1));
        exp = 'x;
        if (dig_q.size() > 0) exp = dig_q.pop_front();
        d0 = digest;
        check("digest", digest, exp);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check("hold_digest", digest, d0);
            check("hold_valid", 256'(digest_valid), 256'(1));
            check("hold_msg_ready", 256'(msg_ready), 256'(0));
        end
        @(posedge clk); #1;
        digest_ready = 1'b1;
        @(posedge clk); #1;
        digest_ready = 1'b0;
        @(negedge clk);
        check("valid_after_hs", 256'(digest_valid), 256'(0));
        check("digest_after_hs", digest, exp);
    endtask

    initial begin
        int n;
        bit seen;
        reset = 1'b0; msg_valid = 1'b0; msg_word = '0; msg_first = 1'b0; msg_last = 1'b0;
        core_done = 1'b0; core_h_out = '0; digest_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            abc_blk[i] = 32'h0;
            tb2[i]     = 32'h0;
        end
        abc_blk[0] = 32'h61626380; abc_blk[15] = 32'h00000018;
        tb1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
                32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        tb2[15] = 32'h000001c0;
        fork
            core_model();
        join_none

        repeat (3) @(negedge clk);
        check("rst_msg_ready", 256'(msg_ready), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_digest_valid", 256'(digest_valid), 256'(0));
        check("rst_digest", digest, 256'(0));
        check("rst_err", 256'(err), 256'(0));
        check("rst_core_start", 256'(core_start), 256'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("ready_release_c0", 256'(msg_ready), 256'(0));
        @(negedge clk);
        check("ready_release_c1", 256'(msg_ready), 256'(1));

        // single-block "abc"
        w_q.push_back('{6'd16, 32'h61626380});
        w_q.push_back('{6'd17, 32'h000f0000});
        dig_q.push_back(ABC_DIG);
        rdy_in_round = 0;
        send_block(abc_blk, 1'b1, 1'b1, 1'b0);
        wait_digest(0);
        check("abc_ready_in_round", 256'(rdy_in_round), 256'(0));

        // two-block message, digest only after the second block
        dig_q.push_back(TWO_DIG);
        send_block(tb1, 1'b1, 1'b0, 1'b0);
        n = 0;
        seen = 0;
        do begin
            @(negedge clk);
            n++;
            if (digest_valid) seen = 1;
        end while (busy && n < 300);
        check("blk1_no_digest", 256'(seen), 256'(0));
        check("blk1_idle", 256'(busy), 256'(0));
        send_block(tb2, 1'b0, 1'b1, 1'b0);
        wait_digest(0);

        // backpressured load plus held digest_ready
        for (int i = 0; i < 16; i++) w_q.push_back('{6'(i), abc_blk[i]});
        w_q.push_back('{6'd16, 32'h61626380});
        w_q.push_back('{6'd17, 32'h000f0000});
        dig_q.push_back(ABC_DIG);
        rdy_in_round = 0;
        send_block(abc_blk, 1'b1, 1'b1, 1'b1);
        wait_digest(10);
        check("bp_ready_in_round", 256'(rdy_in_round), 256'(0));

        // core never answers
        hang = 1;
        send_block(abc_blk, 1'b1, 1'b1, 1'b0);
        wait_round(6'd63);
        repeat (7) @(negedge clk);
        check("tmo_err_c7", 256'(err), 256'(0));
        @(negedge clk);
        check("tmo_err_c8", 256'(err), 256'(1));
        @(negedge clk);
        check("tmo_busy_c9", 256'(busy), 256'(0));
        check("tmo_no_valid", 256'(digest_valid), 256'(0));
        repeat (5) @(negedge clk);
        check("tmo_err_sticky", 256'(err), 256'(1));
        check("tmo_still_no_valid", 256'(digest_valid), 256'(0));
        hang = 0;
        pend = 0;

        // asynchronous reset in the middle of the rounds
        send_block(abc_blk, 1'b1, 1'b1, 1'b0);
        wait_round(6'd30);
        #1 reset = 1'b0;
        #1;
        check("mid_msg_ready", 256'(msg_ready), 256'(0));
        check("mid_busy", 256'(busy), 256'(0));
        check("mid_core_start", 256'(core_start), 256'(0));
        check("mid_round_idx", 256'(round_idx), 256'(0));
        check("mid_core_w_k", {192'd0, core_w, core_k}, 256'(0));
        check("mid_core_h", core_h, 256'(0));
        check("mid_digest", digest, 256'(0));
        check("mid_digest_valid", 256'(digest_valid), 256'(0));
        check("mid_err", 256'(err), 256'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        w_q.delete();
        w_q.push_back('{6'd16, 32'h61626380});
        w_q.push_back('{6'd17, 32'h000f0000});
        dig_q.push_back(ABC_DIG);
        send_block(abc_blk, 1'b1, 1'b1, 1'b0);
        wait_digest(0);

        check("w_queue_drained", 256'(w_q.size()), 256'(0));
        check("dig_queue_drained", 256'(dig_q.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
